axi_tx_packer: RTL and testbench
================================

// Module: axi_tx_packer
// PURPOSE
//  Egress end of the AXI-Stream dataplane. Accepts variable-length byte chunks from the
//  deparser/rewrite stage and packs them into dense AXI-Stream beats (contiguous low tkeep).
//  tlast marks the final beat of each packet. Registered master output with full backpressure.
//  Packets never share a beat.
// PARAMETERS
//  DATA_WIDTH  64  stream width in bits; BYTES = DATA_WIDTH/8 (power of 2, >= 2)
// PORTS
//  clk             in   1                       clock
//  rst_n           in   1                       reset, asynchronous, active-low
//  src_valid       in   1                       chunk valid
//  src_ready       out  1                       chunk accepted when src_valid && src_ready
//  src_data        in   DATA_WIDTH              chunk bytes, byte i at [8i+7:8i], byte 0 first
//  src_nbytes      in   $clog2(BYTES+1)         valid low bytes in src_data, 0..BYTES
//  src_last        in   1                       chunk ends packet
//  m_tvalid        out  1                       AXIS valid
//  m_tready        in   1                       AXIS ready
//  m_tdata         out  DATA_WIDTH              AXIS data
//  m_tkeep         out  BYTES                   AXIS keep, always contiguous from bit 0
//  m_tlast         out  1                       AXIS last
//  empty_last_drop out  1                       1-cycle pulse: zero-length packet discarded
//  busy            out  1                       accumulator non-empty, or m_tvalid high
// BEHAVIOUR
//  Reset
//  - Async reset clears m_tvalid, m_tdata, m_tkeep, m_tlast, empty_last_drop, the accumulator,
//    cnt and the FSM (-> ACCEPT). Outputs read 0 immediately.
//  - src_ready = 1 from the first cycle after release.
//  - Reset mid-packet discards all buffered bytes. No stale bytes appear later.
//  Storage
//  - Accumulator: 2*BYTES bytes; cnt = 0..2*BYTES-1.
//  - Output register holds one beat.
//  Per-cycle order
//  1. Emit, based on registered cnt.
//  2. Append accepted chunk at byte offset (cnt - emitted).
//  Emit
//  - out_free = !m_tvalid || m_tready.
//  - Condition: out_free && (cnt >= BYTES || (state==DRAIN && cnt > 0)).
//  - n = min(cnt, BYTES) low bytes go to m_tdata. m_tkeep = (1<<n)-1. Unused m_tdata bytes = 0.
//  - m_tlast = (state==DRAIN && cnt <= BYTES).
//  - Accumulator shifts down n bytes.
//  - If out_free and no emit: m_tvalid <= 0.
//  - While m_tvalid && !m_tready: m_tdata, m_tkeep and m_tlast hold stable.
//  src_ready
//  - Combinational: src_ready = (state==ACCEPT) && (cnt - emitted_this_cycle < BYTES).
//  - Path m_tready -> src_ready is intentional. It gives full throughput.
//  - src_nbytes > BYTES is clamped to BYTES. src_nbytes = 0 without src_last is a no-op accept.
//  FSM
//  - ACCEPT -> DRAIN: on accept with src_last, when resulting cnt > 0.
//  - ACCEPT -> ACCEPT: on accept with src_last and resulting cnt == 0. empty_last_drop pulses.
//  - DRAIN -> ACCEPT: on the edge that loads the tlast beat. cnt = 0, src_ready = 1 next cycle.
//  Latency
//  - Chunk accepted at edge E is eligible for emit at E+1. m_tvalid rises at E+1 if out_free.
//  Throughput
//  - One BYTES-wide beat per cycle, sustained, with full chunks and m_tready = 1.
// TESTING (DATA_WIDTH=64)
//  1. Chunks of 3,3,2 bytes (0x01..0x08), last on the third, m_tready=1
//     -> one beat: tdata=0x0807060504030201, tkeep=0xFF, tlast=1.
//  2. Chunks of 5,5 bytes, last on the second
//     -> beat1: tkeep=0xFF, tlast=0.
//     -> beat2: tkeep=0x03, tlast=1, tdata[63:16]=0.
//  3. m_tready=0 for 5 cycles with m_tvalid=1
//     -> m_tdata/m_tkeep/m_tlast stable; src_ready falls once cnt>=8; no byte loss or reorder.
//  4. 16 back-to-back 8-byte chunks, last on the 16th, m_tready=1
//     -> 16 consecutive beats, tkeep=0xFF, tlast only on the 16th; src_ready held 1.
//  5. nbytes=0 + last with accumulator empty
//     -> no beat; empty_last_drop high exactly 1 cycle.
//  6. 3 bytes, then nbytes=0 + last
//     -> one beat: tkeep=0x07, tlast=1.
//  7. Assert rst_n low with 6 bytes buffered
//     -> m_tvalid=0 immediately.
//     -> next 2-byte last packet emits tkeep=0x03 carrying only the new bytes.

Source files
------------

// File: rtl/axi_tx_packer.sv
// AXI-Stream egress packer: packs variable-length byte chunks into dense beats with
// contiguous low tkeep, one packet per beat stream, registered master output.
module axi_tx_packer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                src_valid,
  output logic                                src_ready,
  input  logic [DATA_WIDTH-1:0]               src_data,
  input  logic [$clog2(DATA_WIDTH/8+1)-1:0]   src_nbytes,
  input  logic                                src_last,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic [DATA_WIDTH-1:0]               m_tdata,
  output logic [DATA_WIDTH/8-1:0]             m_tkeep,
  output logic                                m_tlast,
  output logic                                empty_last_drop,
  output logic                                busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int AW    = $clog2(2 * BYTES) + 1;
  localparam logic [AW-1:0] BYTES_A = AW'(BYTES);
  localparam logic [AW-1:0] ZERO_A  = {AW{1'b0}};

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_DRAIN  = 1'b1
  } state_t;

  // Keep vector with the low n bits set.
  function automatic logic [BYTES-1:0] keep_mask(input logic [AW-1:0] n);
    logic [BYTES-1:0] k;
    for (int i = 0; i < BYTES; i++) begin
      k[i] = (AW'(i) < n);
    end
    return k;
  endfunction

  // Expand a per-byte keep vector into a per-bit data mask.
  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [BYTES-1:0] k);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < BYTES; i++) begin
      m[8*i +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

  state_t                    state_r;
  state_t                    state_next_s;
  logic [AW-1:0]             cnt_r;
  logic [2*DATA_WIDTH-1:0]   acc_r;

  logic                      m_tvalid_r;
  logic [DATA_WIDTH-1:0]     m_tdata_r;
  logic [BYTES-1:0]          m_tkeep_r;
  logic                      m_tlast_r;
  logic                      drop_r;

  logic                      out_free_s;
  logic                      emit_s;
  logic                      last_beat_s;
  logic [AW-1:0]             n_s;
  logic [AW-1:0]             rem_s;
  logic                      src_ready_s;
  logic                      accept_s;
  logic [AW-1:0]             nb_ext_s;
  logic [AW-1:0]             nb_s;
  logic [AW-1:0]             add_s;
  logic [AW-1:0]             cnt_next_s;
  logic [DATA_WIDTH-1:0]     chunk_s;
  logic [2*DATA_WIDTH-1:0]   acc_next_s;
  logic                      drop_s;

  // Datapath: emit decision from registered cnt, then append the accepted chunk behind
  // whatever remains. src_ready depends on m_tready through the emit term so a full
  // accumulator can drain and refill in the same cycle.
  always_comb begin
    out_free_s  = !m_tvalid_r || m_tready;
    emit_s      = out_free_s &&
                  ((cnt_r >= BYTES_A) || ((state_r == ST_DRAIN) && (cnt_r != ZERO_A)));
    last_beat_s = (state_r == ST_DRAIN) && (cnt_r <= BYTES_A);
    if (emit_s) begin
      if (cnt_r >= BYTES_A) begin
        n_s = BYTES_A;
      end else begin
        n_s = cnt_r;
      end
    end else begin
      n_s = ZERO_A;
    end
    rem_s       = cnt_r - n_s;
    src_ready_s = (state_r == ST_ACCEPT) && (rem_s < BYTES_A);
    accept_s    = src_valid && src_ready_s;
    nb_ext_s    = AW'(src_nbytes);
    if (nb_ext_s > BYTES_A) begin
      nb_s = BYTES_A;
    end else begin
      nb_s = nb_ext_s;
    end
    if (accept_s) begin
      add_s = nb_s;
    end else begin
      add_s = ZERO_A;
    end
    cnt_next_s = rem_s + add_s;
    // Bytes above cnt stay zero, so the shifted accumulator can simply be OR-ed.
    chunk_s    = src_data & byte_mask(keep_mask(add_s));
    acc_next_s = (acc_r >> {n_s, 3'b000}) |
                 ({{DATA_WIDTH{1'b0}}, chunk_s} << {rem_s, 3'b000});
  end

  // Packet FSM next-state and zero-length drop detection.
  always_comb begin
    state_next_s = state_r;
    drop_s       = 1'b0;
    case (state_r)
      ST_ACCEPT: begin
        if (accept_s && src_last) begin
          if (cnt_next_s != ZERO_A) begin
            state_next_s = ST_DRAIN;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          state_next_s = ST_ACCEPT;
        end
      end
      ST_DRAIN: begin
        if (emit_s && last_beat_s) begin
          state_next_s = ST_ACCEPT;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_ACCEPT;
      end
    endcase
  end

  // Accumulator, byte count and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_ACCEPT;
      cnt_r   <= ZERO_A;
      acc_r   <= {(2*DATA_WIDTH){1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      acc_r   <= acc_next_s;
    end
  end

  // Output beat register: load on emit, clear valid when consumed, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid_r <= 1'b0;
      m_tdata_r  <= {DATA_WIDTH{1'b0}};
      m_tkeep_r  <= {BYTES{1'b0}};
      m_tlast_r  <= 1'b0;
    end else if (emit_s) begin
      m_tvalid_r <= 1'b1;
      m_tdata_r  <= acc_r[DATA_WIDTH-1:0] & byte_mask(keep_mask(n_s));
      m_tkeep_r  <= keep_mask(n_s);
      m_tlast_r  <= last_beat_s;
    end else if (out_free_s) begin
      m_tvalid_r <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
    end
  end

  // Single-cycle pulse for a discarded zero-length packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_r <= 1'b0;
    end else begin
      drop_r <= drop_s;
    end
  end

  assign src_ready       = src_ready_s;
  assign m_tvalid        = m_tvalid_r;
  assign m_tdata         = m_tdata_r;
  assign m_tkeep         = m_tkeep_r;
  assign m_tlast         = m_tlast_r;
  assign empty_last_drop = drop_r;
  assign busy            = (cnt_r != ZERO_A) || m_tvalid_r;

endmodule

// File: tb/tb_axi_tx_packer.sv
// Self-checking bench for axi_tx_packer (DATA_WIDTH=64): vector table plus directed
// sequences for backpressure, sustained throughput and mid-packet reset.
module tb_axi_tx_packer;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] src_data;
  logic [3:0]    src_nbytes;
  logic          src_last;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [7:0]    m_tkeep;
  logic          m_tlast;
  logic          empty_last_drop;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_tx_packer #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .src_data        (src_data),
    .src_nbytes      (src_nbytes),
    .src_last        (src_last),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tdata         (m_tdata),
    .m_tkeep         (m_tkeep),
    .m_tlast         (m_tlast),
    .empty_last_drop (empty_last_drop),
    .busy            (busy)
  );

  typedef struct packed {
    logic        v;
    logic [3:0]  nb;
    logic [63:0] d;
    logic        l;
    logic        rdy;
    logic        e_sr;
    logic        e_tv;
    logic [7:0]  e_kp;
    logic [63:0] e_td;
    logic        e_tl;
    logic        e_drop;
    logic        e_busy;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic v, input logic [3:0] nb, input logic [63:0] d,
                              input logic l, input logic rdy, input logic e_sr,
                              input logic e_tv, input logic [7:0] e_kp,
                              input logic [63:0] e_td, input logic e_tl,
                              input logic e_drop, input logic e_busy);
    vec_t r;
    r.v = v; r.nb = nb; r.d = d; r.l = l; r.rdy = rdy;
    r.e_sr = e_sr; r.e_tv = e_tv; r.e_kp = e_kp; r.e_td = e_td; r.e_tl = e_tl;
    r.e_drop = e_drop; r.e_busy = e_busy;
    return r;
  endfunction

  function automatic logic [63:0] chunk16(input int k);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) begin
      d[8*j +: 8] = 8'(128 + k * 8 + j);
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic drive(input logic v, input logic [3:0] nb, input logic [63:0] d,
                       input logic l, input logic rdy);
    @(posedge clk);
    #1;
    src_valid  = v;
    src_nbytes = nb;
    src_data   = d;
    src_last   = l;
    m_tready   = rdy;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    src_valid  = 1'b0;
    src_nbytes = 4'd0;
    src_data   = 64'd0;
    src_last   = 1'b0;
    m_tready   = 1'b0;

    // chunks 3,3,2 -> one full last beat
    tbl[0]  = mk(1'b1, 4'd3,  64'h030201,             1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 4'd3,  64'h060504,             1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
    tbl[2]  = mk(1'b1, 4'd2,  64'h0807,               1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
    tbl[3]  = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 64'h0807060504030201, 1'b1, 1'b0, 1'b1);
    // chunks 5,5 -> full beat then 2-byte last beat
    tbl[5]  = mk(1'b1, 4'd5,  64'h0D0C0B0A09,         1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 4'd5,  64'h1211100F0E,         1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
    tbl[8]  = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 64'h100F0E0D0C0B0A09, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 64'h1211, 1'b1, 1'b0, 1'b1);
    // zero-length last with empty accumulator -> drop pulse only
    tbl[10] = mk(1'b1, 4'd0,  64'hDEAD,               1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
    // 3 bytes then zero-length last -> 3-byte last beat
    tbl[13] = mk(1'b1, 4'd3,  64'h151413,             1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 4'd0,  64'hFFFFFFFF,           1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
    tbl[15] = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
    tbl[16] = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 64'h151413, 1'b1, 1'b0, 1'b1);
    tbl[17] = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
    // nbytes=12 clamps to 8
    tbl[18] = mk(1'b1, 4'd12, 64'h2827262524232221,   1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);
    tbl[19] = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
    tbl[20] = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 64'h2827262524232221, 1'b1, 1'b0, 1'b1);
    tbl[21] = mk(1'b0, 4'd0,  64'h0,                  1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0);

    #1;
    chk("reset m_tvalid", 64'(m_tvalid), 64'd0);
    chk("reset m_tdata",  m_tdata, 64'd0);
    chk("reset m_tkeep",  64'(m_tkeep), 64'd0);
    chk("reset m_tlast",  64'(m_tlast), 64'd0);
    chk("reset drop",     64'(empty_last_drop), 64'd0);
    chk("reset busy",     64'(busy), 64'd0);
    #21;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].nb, tbl[i].d, tbl[i].l, tbl[i].rdy);
      chk($sformatf("vec%0d src_ready", i), 64'(src_ready), 64'(tbl[i].e_sr));
      chk($sformatf("vec%0d m_tvalid", i), 64'(m_tvalid), 64'(tbl[i].e_tv));
      chk($sformatf("vec%0d drop", i), 64'(empty_last_drop), 64'(tbl[i].e_drop));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].e_busy));
      if (tbl[i].e_tv) begin
        chk($sformatf("vec%0d m_tdata", i), m_tdata, tbl[i].e_td);
        chk($sformatf("vec%0d m_tkeep", i), 64'(m_tkeep), 64'(tbl[i].e_kp));
        chk($sformatf("vec%0d m_tlast", i), 64'(m_tlast), 64'(tbl[i].e_tl));
      end
    end

    // Backpressure: beat A held for 5 cycles while chunk C waits.
    drive(1'b1, 4'd8, 64'h3837363534333231, 1'b0, 1'b0);
    chk("bp accept A", 64'(src_ready), 64'd1);
    drive(1'b1, 4'd8, 64'h403F3E3D3C3B3A39, 1'b0, 1'b0);
    chk("bp accept B", 64'(src_ready), 64'd1);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'd4, 64'h44434241, 1'b1, 1'b0);
      chk($sformatf("bp%0d m_tvalid", c), 64'(m_tvalid), 64'd1);
      chk($sformatf("bp%0d m_tdata", c), m_tdata, 64'h3837363534333231);
      chk($sformatf("bp%0d m_tkeep", c), 64'(m_tkeep), 64'hFF);
      chk($sformatf("bp%0d m_tlast", c), 64'(m_tlast), 64'd0);
      chk($sformatf("bp%0d src_ready", c), 64'(src_ready), 64'd0);
    end
    drive(1'b1, 4'd4, 64'h44434241, 1'b1, 1'b1);
    chk("bp release src_ready", 64'(src_ready), 64'd1);
    chk("bp release m_tdata", m_tdata, 64'h3837363534333231);
    drive(1'b0, 4'd0, 64'h0, 1'b0, 1'b1);
    chk("bp beatB m_tdata", m_tdata, 64'h403F3E3D3C3B3A39);
    chk("bp beatB m_tlast", 64'(m_tlast), 64'd0);
    chk("bp beatB src_ready", 64'(src_ready), 64'd0);
    drive(1'b0, 4'd0, 64'h0, 1'b0, 1'b1);
    chk("bp beatC m_tvalid", 64'(m_tvalid), 64'd1);
    chk("bp beatC m_tdata", m_tdata, 64'h44434241);
    chk("bp beatC m_tkeep", 64'(m_tkeep), 64'h0F);
    chk("bp beatC m_tlast", 64'(m_tlast), 64'd1);
    drive(1'b0, 4'd0, 64'h0, 1'b0, 1'b1);
    chk("bp idle m_tvalid", 64'(m_tvalid), 64'd0);

    // Sustained throughput: 16 full chunks, beat k visible two cycles after its chunk.
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        drive(1'b1, 4'd8, chunk16(k), k == 15, 1'b1);
        chk($sformatf("tp%0d src_ready", k), 64'(src_ready), 64'd1);
      end else begin
        drive(1'b0, 4'd0, 64'h0, 1'b0, 1'b1);
      end
      if (k >= 2) begin
        chk($sformatf("tp%0d m_tvalid", k), 64'(m_tvalid), 64'd1);
        chk($sformatf("tp%0d m_tdata", k), m_tdata, chunk16(k - 2));
        chk($sformatf("tp%0d m_tkeep", k), 64'(m_tkeep), 64'hFF);
        chk($sformatf("tp%0d m_tlast", k), 64'(m_tlast), 64'(k == 17));
      end else begin
        chk($sformatf("tp%0d m_tvalid", k), 64'(m_tvalid), 64'd0);
      end
    end
    drive(1'b0, 4'd0, 64'h0, 1'b0, 1'b1);
    chk("tp idle m_tvalid", 64'(m_tvalid), 64'd0);

    // Reset with a pending beat and 6 buffered bytes.
    drive(1'b1, 4'd8, 64'h5857565554535251, 1'b0, 1'b0);
    chk("rst fill src_ready", 64'(src_ready), 64'd1);
    drive(1'b1, 4'd6, 64'h666564636261, 1'b0, 1'b0);
    chk("rst fill2 src_ready", 64'(src_ready), 64'd1);
    drive(1'b0, 4'd0, 64'h0, 1'b0, 1'b0);
    chk("rst pre m_tvalid", 64'(m_tvalid), 64'd1);
    chk("rst pre busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst async m_tdata", m_tdata, 64'd0);
    chk("rst async busy", 64'(busy), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 4'd2, 64'hFFFFFFFFFFFF7271, 1'b1, 1'b1);
    chk("post-rst src_ready", 64'(src_ready), 64'd1);
    chk("post-rst m_tvalid", 64'(m_tvalid), 64'd0);
    drive(1'b0, 4'd0, 64'h0, 1'b0, 1'b1);
    chk("post-rst drain src_ready", 64'(src_ready), 64'd0);
    drive(1'b0, 4'd0, 64'h0, 1'b0, 1'b1);
    chk("post-rst m_tvalid beat", 64'(m_tvalid), 64'd1);
    chk("post-rst m_tdata", m_tdata, 64'h7271);
    chk("post-rst m_tkeep", 64'(m_tkeep), 64'h03);
    chk("post-rst m_tlast", 64'(m_tlast), 64'd1);
    drive(1'b0, 4'd0, 64'h0, 1'b0, 1'b1);
    chk("post-rst idle m_tvalid", 64'(m_tvalid), 64'd0);
    chk("post-rst idle busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
